// File: rtl/axis_pktrecv_pkg.sv
// Shared constants and byte-count helper for the AXI-stream packet receiver.
package axis_pktrecv_pkg;

  localparam int C_DEF_DATA_WIDTH = 32;
  localparam int C_DEF_ID_WIDTH   = 1;
  localparam int C_DEF_DEST_WIDTH = 1;
  localparam int C_DEF_USER_WIDTH = 1;
  localparam int C_DEF_LGLEN      = 16;
  localparam int C_DEF_MAX_PACKET = 1500;
  // Widest supported byte-lane mask (1024-bit TDATA).
  localparam int C_MAX_STRB       = 128;

  // Data bytes in a beat: lanes that are both kept and data-qualified.
  function automatic logic [7:0] vbytes(input logic [C_MAX_STRB-1:0] keep,
                                        input logic [C_MAX_STRB-1:0] strb);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < C_MAX_STRB; i++)
      n = n + {7'd0, keep[i] & strb[i]};
    return n;
  endfunction

endpackage

// File: rtl/axis_pktrecv_skidbuffer.sv
// Registered-output skid buffer: one output register plus one overflow slot.
module skidbuffer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          skid_full;
  logic [DW-1:0] skid_data;

  assign in_ready = !skid_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (!out_valid || out_ready) begin
      // Output slot frees up: the older skid beat always goes first.
      if (skid_full) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        skid_full <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_full) begin
      skid_full <= 1'b1;
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/axis_pktrecv.sv
// AXI-stream pass-through that measures packet byte length and reports it per TLAST.
// Optional: AXIS_PKTRECV_OVERSIZE_DROP_EN drops beats past MAX_PACKET and zero-masks the TLAST beat.
module axis_pktrecv
  import axis_pktrecv_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = C_DEF_DATA_WIDTH,
  parameter int C_AXIS_ID_WIDTH   = C_DEF_ID_WIDTH,
  parameter int C_AXIS_DEST_WIDTH = C_DEF_DEST_WIDTH,
  parameter int C_AXIS_USER_WIDTH = C_DEF_USER_WIDTH,
  parameter int LGLEN             = C_DEF_LGLEN,
  parameter int MAX_PACKET        = C_DEF_MAX_PACKET
) (
  input  logic                           i_aclk,
  input  logic                           i_aresetn,
  input  logic                           S_AXIS_TVALID,
  output logic                           S_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                           S_AXIS_TLAST,
  input  logic [C_AXIS_ID_WIDTH-1:0]     S_AXIS_TID,
  input  logic [C_AXIS_DEST_WIDTH-1:0]   S_AXIS_TDEST,
  input  logic [C_AXIS_USER_WIDTH-1:0]   S_AXIS_TUSER,
  output logic                           M_AXIS_TVALID,
  input  logic                           M_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                           M_AXIS_TLAST,
  output logic [C_AXIS_ID_WIDTH-1:0]     M_AXIS_TID,
  output logic [C_AXIS_DEST_WIDTH-1:0]   M_AXIS_TDEST,
  output logic [C_AXIS_USER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                           o_len_valid,
  input  logic                           i_len_ready,
  output logic [LGLEN-1:0]               o_len,
  output logic                           o_len_oversize
);

  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int PW = C_AXIS_DATA_WIDTH + 2*SW + 1 + C_AXIS_ID_WIDTH
                    + C_AXIS_DEST_WIDTH + C_AXIS_USER_WIDTH;
  localparam logic [LGLEN:0] MAXP = (LGLEN+1)'(MAX_PACKET);

  logic             skid_ready, accept, push;
  logic [LGLEN-1:0] len, sum_sat;
  logic [7:0]       vb;
  logic [LGLEN:0]   sum;
  logic             over, drop_beat, zero_last;
  logic [SW-1:0]    f_keep, f_strb;
  logic [PW-1:0]    s_pay, m_pay;

  assign S_AXIS_TREADY = i_aresetn && skid_ready && !o_len_valid;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;

  assign vb      = vbytes(C_MAX_STRB'(S_AXIS_TKEEP), C_MAX_STRB'(S_AXIS_TSTRB));
  assign sum     = {1'b0, len} + (LGLEN+1)'(vb);
  assign sum_sat = sum[LGLEN] ? '1 : sum[LGLEN-1:0];
  assign over    = sum > MAXP;

`ifdef AXIS_PKTRECV_OVERSIZE_DROP_EN
  // Sticky until TLAST: once a beat was dropped the packet is oversize.
  logic dropped;
  assign drop_beat = !S_AXIS_TLAST && over;
  assign zero_last = S_AXIS_TLAST && (dropped || over);

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn)  dropped <= 1'b0;
    else if (accept) dropped <= S_AXIS_TLAST ? 1'b0 : (dropped || drop_beat);
  end
`else
  assign drop_beat = 1'b0;
  assign zero_last = 1'b0;
`endif

  assign push   = accept && !drop_beat;
  assign f_keep = zero_last ? '0 : S_AXIS_TKEEP;
  assign f_strb = zero_last ? '0 : S_AXIS_TSTRB;
  assign s_pay  = {S_AXIS_TDATA, f_strb, f_keep, S_AXIS_TLAST,
                   S_AXIS_TID, S_AXIS_TDEST, S_AXIS_TUSER};

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      len            <= '0;
      o_len          <= '0;
      o_len_oversize <= 1'b0;
      o_len_valid    <= 1'b0;
    end else begin
      if (o_len_valid && i_len_ready) o_len_valid <= 1'b0;
      // accept implies !o_len_valid, so the set below never races the clear.
      if (accept) begin
        if (S_AXIS_TLAST) begin
          o_len_valid <= 1'b1;
          len         <= '0;
`ifdef AXIS_PKTRECV_OVERSIZE_DROP_EN
          o_len          <= zero_last ? len : sum_sat;
          o_len_oversize <= over || dropped;
`else
          o_len          <= sum_sat;
          o_len_oversize <= over;
`endif
        end else if (!drop_beat) begin
          len <= sum_sat;
        end
      end
    end
  end

  skidbuffer #(.DW(PW)) u_skid (
    .clk       (i_aclk),
    .rst_n     (i_aresetn),
    .in_valid  (push),
    .in_ready  (skid_ready),
    .in_data   (s_pay),
    .out_valid (M_AXIS_TVALID),
    .out_ready (M_AXIS_TREADY),
    .out_data  (m_pay)
  );

  assign {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TKEEP, M_AXIS_TLAST,
          M_AXIS_TID, M_AXIS_TDEST, M_AXIS_TUSER} = m_pay;

endmodule

// File: tb/tb_axis_pktrecv.sv
// Directed bench for axis_pktrecv: packet vector table plus stall/reset/oversize sequences.
module tb_axis_pktrecv;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  k;
    logic        l;
    logic        id;
    logic        dst;
    logic        u;
  } beat_t;

  typedef struct {
    beat_t b;
    int    exp_len;
    bit    exp_ov;
  } vec_t;

  logic        i_aclk, i_aresetn;
  logic        S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [31:0] S_AXIS_TDATA;
  logic [3:0]  S_AXIS_TSTRB, S_AXIS_TKEEP;
  logic        S_AXIS_TID, S_AXIS_TDEST, S_AXIS_TUSER;
  logic        M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TSTRB, M_AXIS_TKEEP;
  logic        M_AXIS_TID, M_AXIS_TDEST, M_AXIS_TUSER;
  logic        o_len_valid, i_len_ready, o_len_oversize;
  logic [15:0] o_len;

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  vec_t  tbl[12];

  axis_pktrecv dut (
    .i_aclk(i_aclk), .i_aresetn(i_aresetn),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
    .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TID(S_AXIS_TID), .S_AXIS_TDEST(S_AXIS_TDEST), .S_AXIS_TUSER(S_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TID(M_AXIS_TID), .M_AXIS_TDEST(M_AXIS_TDEST), .M_AXIS_TUSER(M_AXIS_TUSER),
    .o_len_valid(o_len_valid), .i_len_ready(i_len_ready),
    .o_len(o_len), .o_len_oversize(o_len_oversize)
  );

  initial i_aclk = 1'b0;
  always #5 i_aclk = ~i_aclk;

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                               input logic l, input logic id, input logic dst, input logic u);
    beat_t b;
    b.d = d; b.k = k; b.s = s; b.l = l; b.id = id; b.dst = dst; b.u = u;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pops the expectation queue on every M-side handshake.
  task automatic monitor();
    beat_t got, e;
    forever begin
      @(negedge i_aclk);
      if (i_aresetn && M_AXIS_TVALID && M_AXIS_TREADY) begin
        got = {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TKEEP, M_AXIS_TLAST,
               M_AXIS_TID, M_AXIS_TDEST, M_AXIS_TUSER};
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL m_unexpected_beat: got %0h expected no beat", got);
        end else begin
          e = exp_q.pop_front();
          chk("m_beat", 64'(got), 64'(e));
        end
      end
    end
  endtask

  // Holds the beat until accepted; fwd/zk describe what M must carry for it.
  task automatic send(input beat_t b, input bit fwd, input bit zk);
    int    n;
    bit    ok;
    beat_t e;
    n = 0; ok = 1'b0;
    S_AXIS_TVALID = 1'b1;
    {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TKEEP, S_AXIS_TLAST,
     S_AXIS_TID, S_AXIS_TDEST, S_AXIS_TUSER} = b;
    while (!ok && n < 200) begin
      @(negedge i_aclk);
      if (S_AXIS_TREADY) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      if (fwd) begin
        e = b;
        if (zk) begin e.k = '0; e.s = '0; end
        exp_q.push_back(e);
      end
      @(posedge i_aclk); #1;
    end else begin
      checks++; failures++;
      $display("FAIL send_timeout: got no TREADY for data %0h expected accept", b.d);
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic check_report(input string nm, input int exp_len, input bit exp_ov);
    int n;
    n = 0;
    while (!o_len_valid && n < 20) begin @(posedge i_aclk); #1; n++; end
    chk({nm, "_valid"}, 64'(o_len_valid), 64'd1);
    chk({nm, "_len"}, 64'(o_len), 64'(exp_len));
    chk({nm, "_ov"}, 64'(o_len_oversize), 64'(exp_ov));
    chk({nm, "_tready_blocked"}, 64'(S_AXIS_TREADY), 64'd0);
    i_len_ready = 1'b1;
    @(posedge i_aclk); #1;
    i_len_ready = 1'b0;
    chk({nm, "_cleared"}, 64'(o_len_valid), 64'd0);
  endtask

  initial begin
    int exp_big;
    beat_t b1;

    // Packet vectors: expected length/oversize apply on the TLAST row.
    tbl[0].b  = mk(32'h0000_0001, 4'hF, 4'hF, 0, 0, 0, 0); tbl[0].exp_len  = 0;  tbl[0].exp_ov  = 0;
    tbl[1].b  = mk(32'h0000_0002, 4'hF, 4'hF, 0, 0, 0, 0); tbl[1].exp_len  = 0;  tbl[1].exp_ov  = 0;
    tbl[2].b  = mk(32'h0000_0003, 4'hF, 4'hF, 0, 0, 0, 0); tbl[2].exp_len  = 0;  tbl[2].exp_ov  = 0;
    tbl[3].b  = mk(32'h0000_0004, 4'h3, 4'h3, 1, 1, 0, 1); tbl[3].exp_len  = 14; tbl[3].exp_ov  = 0;
    tbl[4].b  = mk(32'hDEAD_BEEF, 4'h0, 4'h1, 1, 0, 1, 0); tbl[4].exp_len  = 0;  tbl[4].exp_ov  = 0;
    tbl[5].b  = mk(32'h1234_5678, 4'hF, 4'h5, 0, 1, 1, 0); tbl[5].exp_len  = 0;  tbl[5].exp_ov  = 0;
    tbl[6].b  = mk(32'h9ABC_DEF0, 4'hA, 4'hF, 0, 0, 0, 1); tbl[6].exp_len  = 0;  tbl[6].exp_ov  = 0;
    tbl[7].b  = mk(32'h0F0F_0F0F, 4'h1, 4'h1, 1, 1, 1, 1); tbl[7].exp_len  = 5;  tbl[7].exp_ov  = 0;
    tbl[8].b  = mk(32'hCAFE_0000, 4'h0, 4'h0, 0, 0, 1, 1); tbl[8].exp_len  = 0;  tbl[8].exp_ov  = 0;
    tbl[9].b  = mk(32'hCAFE_0001, 4'h7, 4'h7, 1, 0, 1, 1); tbl[9].exp_len  = 3;  tbl[9].exp_ov  = 0;
    tbl[10].b = mk(32'h5555_AAAA, 4'hF, 4'hF, 1, 1, 0, 0); tbl[10].exp_len = 4;  tbl[10].exp_ov = 0;
    tbl[11].b = mk(32'hA5A5_5A5A, 4'hC, 4'h3, 1, 0, 0, 1); tbl[11].exp_len = 0;  tbl[11].exp_ov = 0;

    i_aresetn = 1'b0; S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0;
    S_AXIS_TKEEP = '0; S_AXIS_TLAST = 1'b0; S_AXIS_TID = 1'b0; S_AXIS_TDEST = 1'b0;
    S_AXIS_TUSER = 1'b0; M_AXIS_TREADY = 1'b1; i_len_ready = 1'b0;
    fork monitor(); join_none

    repeat (3) @(posedge i_aclk);
    #1;
    chk("rst_tready", 64'(S_AXIS_TREADY), 64'd0);
    chk("rst_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst_len_valid", 64'(o_len_valid), 64'd0);
    chk("rst_len", 64'(o_len), 64'd0);
    chk("rst_ov", 64'(o_len_oversize), 64'd0);
    i_aresetn = 1'b1;
    @(posedge i_aclk); #1;
    chk("tready_after_rst", 64'(S_AXIS_TREADY), 64'd1);

    // Table: each beat must sit on M one cycle after its accept edge.
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].b, 1'b1, 1'b0);
      chk("lat_valid", 64'(M_AXIS_TVALID), 64'd1);
      chk("lat_data", 64'(M_AXIS_TDATA), 64'(tbl[i].b.d));
      if (tbl[i].b.l) check_report("tbl_rep", tbl[i].exp_len, tbl[i].exp_ov);
    end

    // Downstream stall: two beats absorbed, then TREADY drops and M holds.
    M_AXIS_TREADY = 1'b0;
    b1 = mk(32'hB000_0001, 4'hF, 4'hF, 0, 0, 0, 0);
    send(b1, 1'b1, 1'b0);
    send(mk(32'hB000_0002, 4'hF, 4'hF, 0, 1, 0, 0), 1'b1, 1'b0);
    chk("stall_tready", 64'(S_AXIS_TREADY), 64'd0);
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = 32'hB000_0003;
    for (int c = 0; c < 5; c++) begin
      @(posedge i_aclk); #1;
      chk("stall_hold_valid", 64'(M_AXIS_TVALID), 64'd1);
      chk("stall_hold_data", 64'({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST}),
          64'({b1.d, b1.k, b1.l}));
      chk("stall_tready_low", 64'(S_AXIS_TREADY), 64'd0);
    end
    M_AXIS_TREADY = 1'b1;
    send(mk(32'hB000_0003, 4'hF, 4'hF, 0, 0, 1, 0), 1'b1, 1'b0);
    send(mk(32'hB000_0004, 4'hF, 4'hF, 1, 0, 0, 1), 1'b1, 1'b0);
    check_report("stall_rep", 16, 0);

    // Report held by i_len_ready=0; next packet waits, then goes one cycle after.
    send(mk(32'hC000_0001, 4'hF, 4'hF, 1, 0, 0, 0), 1'b1, 1'b0);
    S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = 32'hC000_0002;
    for (int c = 0; c < 3; c++) begin
      chk("hold_valid", 64'(o_len_valid), 64'd1);
      chk("hold_len", 64'(o_len), 64'd4);
      chk("hold_tready", 64'(S_AXIS_TREADY), 64'd0);
      @(posedge i_aclk); #1;
    end
    i_len_ready = 1'b1;
    @(posedge i_aclk); #1;
    i_len_ready = 1'b0;
    chk("hold_released", 64'(o_len_valid), 64'd0);
    chk("hold_tready_back", 64'(S_AXIS_TREADY), 64'd1);
    send(mk(32'hC000_0002, 4'h1, 4'h1, 1, 1, 1, 1), 1'b1, 1'b0);
    check_report("hold_next_rep", 1, 0);

    // 1504-byte packet against MAX_PACKET=1500.
    for (int i = 0; i < 376; i++) begin
`ifdef AXIS_PKTRECV_OVERSIZE_DROP_EN
      send(mk(32'(i), 4'hF, 4'hF, i == 375, 0, 0, 0), 1'b1, i == 375);
`else
      send(mk(32'(i), 4'hF, 4'hF, i == 375, 0, 0, 0), 1'b1, 1'b0);
`endif
    end
`ifdef AXIS_PKTRECV_OVERSIZE_DROP_EN
    exp_big = 1500;
`else
    exp_big = 1504;
`endif
    check_report("oversize_rep", exp_big, 1);

    // Reset mid-packet: partial discarded, next packet counts from zero.
    send(mk(32'hD000_0001, 4'hF, 4'hF, 0, 0, 0, 0), 1'b1, 1'b0);
    send(mk(32'hD000_0002, 4'hF, 4'hF, 0, 0, 0, 0), 1'b1, 1'b0);
    repeat (3) @(posedge i_aclk);
    #1;
    i_aresetn = 1'b0;
    #1;
    chk("midrst_tready", 64'(S_AXIS_TREADY), 64'd0);
    chk("midrst_mvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("midrst_len_valid", 64'(o_len_valid), 64'd0);
    chk("midrst_len", 64'(o_len), 64'd0);
    @(posedge i_aclk); #1;
    i_aresetn = 1'b1;
    @(posedge i_aclk); #1;
    chk("midrst_no_report", 64'(o_len_valid), 64'd0);
    chk("midrst_queue", 64'(exp_q.size()), 64'd0);
    send(mk(32'hE000_0001, 4'hF, 4'hF, 0, 0, 0, 0), 1'b1, 1'b0);
    send(mk(32'hE000_0002, 4'h3, 4'h3, 1, 0, 0, 0), 1'b1, 1'b0);
    check_report("midrst_next_rep", 6, 0);

    repeat (4) @(posedge i_aclk);
    #1;
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pktrecv.md
AXIS_PKTRECV -- requirements
Module: axis_pktrecv

Interface
REQ-001 SHALL have parameters: C_AXIS_DATA_WIDTH=32, byte-multiple TDATA width; C_AXIS_ID_WIDTH=1, TID width; C_AXIS_DEST_WIDTH=1, TDEST width; C_AXIS_USER_WIDTH=1, TUSER width; LGLEN=16, packet-length counter width; MAX_PACKET=1500, oversize threshold in bytes.
REQ-002 SHALL have one clock and an asynchronous active-low reset: i_aclk  in  1  clock; i_aresetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have the following slave stream ports: S_AXIS_TVALID in 1; S_AXIS_TREADY out 1; S_AXIS_TDATA in DW; S_AXIS_TSTRB in DW/8; S_AXIS_TKEEP in DW/8; S_AXIS_TLAST in 1; S_AXIS_TID in IDW; S_AXIS_TDEST in DESTW; S_AXIS_TUSER in UW.
REQ-004 SHALL have the following master stream ports, with the same widths as their slave counterparts: M_AXIS_TVALID out; M_AXIS_TREADY in; M_AXIS_TDATA/TSTRB/TKEEP/TLAST/TID/TDEST/TUSER out.
REQ-005 SHALL have the following length-report ports: o_len_valid out 1, report pending; i_len_ready in 1, report consumed; o_len out LGLEN, packet byte count; o_len_oversize out 1, packet exceeded MAX_PACKET.

Function
REQ-006 SHALL accept a slave beat only on S_AXIS_TVALID && S_AXIS_TREADY.
REQ-007 SHALL drive S_AXIS_TREADY = i_aresetn && !skid_full && !o_len_valid.
REQ-008 SHALL forward each accepted beat to the M_AXIS registers with 1-cycle latency, unaltered, and sustain 1 beat/cycle while M_AXIS_TREADY is high.
REQ-009 SHALL hold M_AXIS_TVALID and all M_AXIS payload stable while M_AXIS_TVALID && !M_AXIS_TREADY, buffering at most one additional beat in the skid stage.
REQ-010 SHALL compute valid bytes per beat as vbytes = popcount(TKEEP & TSTRB), counting reserved (TKEEP=0, TSTRB=1) lanes as zero.
REQ-011 SHALL keep a running count len, LGLEN bits, that adds vbytes on each accepted non-TLAST beat and saturates at 2^LGLEN-1 without wrapping.
REQ-012 SHALL, on an accepted TLAST beat, load o_len = sat(len+vbytes), set o_len_oversize = (len+vbytes > MAX_PACKET), set o_len_valid, and clear len to 0 in the same cycle.
REQ-013 SHALL clear o_len_valid on o_len_valid && i_len_ready, and SHALL hold o_len and o_len_oversize stable while o_len_valid && !i_len_ready.
REQ-014 SHALL deassert TREADY while a report is pending, so a minimum one-cycle gap follows every TLAST; back-to-back 1-beat packets therefore run at 1 beat per 2 cycles with i_len_ready tied high.
REQ-015 SHALL treat a TLAST beat with vbytes=0 as a valid packet end, reporting o_len=len.
REQ-016 SHALL track all TID/TDEST/TUSER combinations as one interleaved stream: a single counter, no per-route state.

Reset
REQ-017 SHALL, while i_aresetn=0, force S_AXIS_TREADY=0, M_AXIS_TVALID=0, o_len_valid=0, o_len=0, o_len_oversize=0, len=0, skid empty.
REQ-018 SHALL, on reset asserted mid-packet, discard the partial packet with no report, and SHALL NOT emit M_AXIS_TLAST for that packet.
REQ-019 SHALL raise S_AXIS_TREADY on the first clock edge after reset release.

Configuration
REQ-020 SHALL, with macro AXIS_PKTRECV_OVERSIZE_DROP_EN defined, consume but not forward non-TLAST beats for which len+vbytes > MAX_PACKET.
REQ-021 SHALL, with AXIS_PKTRECV_OVERSIZE_DROP_EN defined, forward the closing TLAST beat of an oversize packet with TKEEP=0 and TSTRB=0, and report o_len equal to the bytes actually forwarded, which is <= MAX_PACKET.
REQ-022 SHALL, without AXIS_PKTRECV_OVERSIZE_DROP_EN, forward all beats, report the true count (saturated), and still set o_len_oversize.

Structure
REQ-023 SHALL place the vbytes popcount function and the default width and MAX_PACKET constants in shared package axis_pktrecv_pkg.
REQ-024 SHALL implement the input/output staging as one instance of sub-module skidbuffer, registered-output mode, with payload width DW+2*DW/8+1+IDW+DESTW+UW.

Verification
REQ-025 SHALL pass this scenario: reset released, 4-beat packet with TKEEP=TSTRB=4'hF, last beat 4'h3 -> o_len=14, o_len_oversize=0, M_AXIS carries the 4 identical beats 1 cycle delayed.
REQ-026 SHALL pass this scenario: M_AXIS_TREADY=0 for 5 cycles mid-packet -> M_AXIS payload stable, S_AXIS_TREADY drops after at most 2 accepted beats, no beat lost.
REQ-027 SHALL pass this scenario: TLAST accepted with i_len_ready=0 for 3 cycles -> o_len stable, S_AXIS_TREADY=0 throughout, next packet accepted 1 cycle after the handshake.
REQ-028 SHALL pass this scenario: 1504-byte packet, MAX_PACKET=1500, 32-bit beats -> o_len_oversize=1; with macro, o_len=1500 and the last data beat is dropped; without macro, o_len=1504.
REQ-029 SHALL pass this scenario: i_aresetn pulsed low after beat 2 of a 4-beat packet -> no report, outputs zero, next packet reports its own length only.
REQ-030 SHALL pass this scenario: a beat with TKEEP=4'h0, TSTRB=4'h1, TLAST=1 -> counted as 0 bytes, forwarded unchanged.
